// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU drawing pipeline: shape codes, widths and
// the rasterizer state encoding.
package gpu_pkg;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 24;
    localparam int CNT_W   = COORD_W + 1;

    localparam logic [3:0] SHAPE_CLEAR = 4'd0;
    localparam logic [3:0] SHAPE_LINE  = 4'd1;
    localparam logic [3:0] SHAPE_RECT  = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLEAR,
        ST_LINE,
        ST_RECT,
        ST_DONE
    } rast_state_e;

endpackage

// File: rtl/bresenham_step.sv
// One combinational step of integer Bresenham: current point and error term in,
// next point and error term out, plus a flag for "current point is the endpoint".
module bresenham_step
    import gpu_pkg::*;
(
    input  logic        [CNT_W-1:0] x_i,
    input  logic        [CNT_W-1:0] y_i,
    input  logic signed [9:0]       err_i,
    input  logic signed [9:0]       dx_i,
    input  logic signed [9:0]       dy_i,
    input  logic                    sx_neg_i,
    input  logic                    sy_neg_i,
    input  logic        [CNT_W-1:0] x_end_i,
    input  logic        [CNT_W-1:0] y_end_i,
    output logic        [CNT_W-1:0] x_o,
    output logic        [CNT_W-1:0] y_o,
    output logic signed [9:0]       err_o,
    output logic                    at_end_o
);

    logic signed [10:0] err_w;
    logic signed [10:0] dx_w;
    logic signed [10:0] dy_w;
    logic signed [10:0] e2;
    logic               step_x;
    logic               step_y;

    assign err_w = err_i;
    assign dx_w  = dx_i;
    assign dy_w  = dy_i;
    assign e2    = err_w <<< 1;

    // Both tests use the error term from before this step's updates.
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);

    assign err_o = err_i + (step_x ? dy_i : 10'sd0) + (step_y ? dx_i : 10'sd0);
    assign x_o   = step_x ? (sx_neg_i ? x_i - 9'd1 : x_i + 9'd1) : x_i;
    assign y_o   = step_y ? (sy_neg_i ? y_i - 9'd1 : y_i + 9'd1) : y_i;

    assign at_end_o = (x_i == x_end_i) && (y_i == y_end_i);

endmodule

// File: rtl/shape_rasterizer.sv
// Walks a clear, line or rectangle command and emits one clipped pixel write
// per valid/ready handshake toward the framebuffer writer.
module shape_rasterizer
    import gpu_pkg::*;
#(
    parameter int SCREEN_W = 128,
    parameter int SCREEN_H = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         shape_type,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               fill_enable,
    input  logic [COLOR_W-1:0] color,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done,
    output logic               cmd_err
);

    localparam logic [9:0]       W_LIM = 10'(SCREEN_W);
    localparam logic [9:0]       H_LIM = 10'(SCREEN_H);
    localparam logic [CNT_W-1:0] XLAST = CNT_W'(SCREEN_W - 1);
    localparam logic [CNT_W-1:0] YLAST = CNT_W'(SCREEN_H - 1);

    rast_state_e               state_q;
    logic [3:0]                type_q;
    logic [COORD_W-1:0]        x0_q, y0_q, x1_q, y1_q;
    logic                      fill_q;
    logic [COLOR_W-1:0]        col_q;
    logic [CNT_W-1:0]          cx_q, cy_q;
    logic [CNT_W-1:0]          xmin_q, xmax_q, ymin_q, ymax_q;
    logic signed [9:0]         err_q, dx_q, dy_q;
    logic                      sxn_q, syn_q;
    logic                      vld_q, busy_q, done_q, cerr_q;

    logic signed [9:0]         ddx, ddy, adx, ady;
    logic [COORD_W-1:0]        xlo, xhi, ylo, yhi;
    logic [CNT_W-1:0]          bx, by;
    logic signed [9:0]         berr;
    logic                      bend;
    logic [CNT_W-1:0]          nx_d, ny_d;
    logic                      last_d;
    logic                      emit, adv;

    function automatic logic on_screen(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
        return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    endfunction

    assign ddx = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
    assign ddy = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
    assign adx = ddx[9] ? -ddx : ddx;
    assign ady = ddy[9] ? -ddy : ddy;
    assign xlo = (x0_q < x1_q) ? x0_q : x1_q;
    assign xhi = (x0_q < x1_q) ? x1_q : x0_q;
    assign ylo = (y0_q < y1_q) ? y0_q : y1_q;
    assign yhi = (y0_q < y1_q) ? y1_q : y0_q;

    bresenham_step u_step (
        .x_i      (cx_q),
        .y_i      (cy_q),
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_neg_i (sxn_q),
        .sy_neg_i (syn_q),
        .x_end_i  ({1'b0, x1_q}),
        .y_end_i  ({1'b0, y1_q}),
        .x_o      (bx),
        .y_o      (by),
        .err_o    (berr),
        .at_end_o (bend)
    );

    // Next candidate for whichever shape is being walked.
    always_comb begin
        nx_d   = cx_q;
        ny_d   = cy_q;
        last_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                last_d = (cx_q == XLAST) && (cy_q == YLAST);
                if (cx_q == XLAST) begin
                    nx_d = '0;
                    ny_d = cy_q + 9'd1;
                end else begin
                    nx_d = cx_q + 9'd1;
                end
            end
            ST_LINE: begin
                nx_d   = bx;
                ny_d   = by;
                last_d = bend;
            end
            ST_RECT: begin
                last_d = (cx_q == xmax_q) && (cy_q == ymax_q);
                if (cx_q == xmax_q) begin
                    nx_d = xmin_q;
                    ny_d = cy_q + 9'd1;
                end else if (fill_q || (cy_q == ymin_q) || (cy_q == ymax_q)) begin
                    nx_d = cx_q + 9'd1;
                end else begin
                    nx_d = xmax_q;
                end
            end
            default: ;
        endcase
    end

    assign emit = (state_q == ST_CLEAR) || (state_q == ST_LINE) || (state_q == ST_RECT);
    // A clipped candidate (vld_q=0) retires on its own in one cycle.
    assign adv  = emit && (!vld_q || pix_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            fill_q  <= 1'b0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            err_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cerr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        type_q  <= shape_type;
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        fill_q  <= fill_enable;
                        col_q   <= (shape_type == SHAPE_CLEAR) ? bg_color : color;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx_q   <= adx;
                    dy_q   <= -ady;
                    err_q  <= adx - ady;
                    sxn_q  <= ddx[9];
                    syn_q  <= ddy[9];
                    xmin_q <= {1'b0, xlo};
                    xmax_q <= {1'b0, xhi};
                    ymin_q <= {1'b0, ylo};
                    ymax_q <= {1'b0, yhi};
                    case (type_q)
                        SHAPE_CLEAR: begin
                            cx_q    <= '0;
                            cy_q    <= '0;
                            vld_q   <= 1'b1;
                            state_q <= ST_CLEAR;
                        end
                        SHAPE_LINE: begin
                            cx_q    <= {1'b0, x0_q};
                            cy_q    <= {1'b0, y0_q};
                            vld_q   <= on_screen({1'b0, x0_q}, {1'b0, y0_q});
                            state_q <= ST_LINE;
                        end
                        SHAPE_RECT: begin
                            cx_q    <= {1'b0, xlo};
                            cy_q    <= {1'b0, ylo};
                            vld_q   <= on_screen({1'b0, xlo}, {1'b0, ylo});
                            state_q <= ST_RECT;
                        end
                        default: begin
                            done_q  <= 1'b1;
                            cerr_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    endcase
                end
                ST_CLEAR, ST_LINE, ST_RECT: begin
                    if (adv) begin
                        if (last_d) begin
                            vld_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cx_q  <= nx_d;
                            cy_q  <= ny_d;
                            vld_q <= on_screen(nx_d, ny_d);
                            if (state_q == ST_LINE) begin
                                err_q <= berr;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix_valid = vld_q;
    assign pix_x     = cx_q[COORD_W-1:0];
    assign pix_y     = cy_q[COORD_W-1:0];
    assign pix_color = col_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = cerr_q;

endmodule

// File: tb/tb_shape_rasterizer.sv
// Directed bench for shape_rasterizer: a 4x4 instance for clear, a 128x128
// instance for lines, rectangles, clipping, errors and reset interference.
module tb_shape_rasterizer;

    localparam logic [23:0] FG = 24'hFF0000;
    localparam logic [23:0] BG = 24'h0000FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s = 1'b0, start_b = 1'b0;
    logic [3:0]  shape_type = '0;
    logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        fill_enable = 1'b0;
    logic [23:0] color = FG, bg_color = BG;
    logic        rdy_s = 1'b1, rdy_b = 1'b1;

    logic        pv_s, busy_s, done_s, err_s;
    logic [7:0]  px_s, py_s;
    logic [23:0] pc_s;
    logic        pv_b, busy_b, done_b, err_b;
    logic [7:0]  px_b, py_b;
    logic [23:0] pc_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Results of the most recent run_cmd.
    logic [15:0] got[$];
    int first_vld, done_cyc, last_hs, stall_bad, color_bad;
    bit got_done, err_at_done, busy_at_done, busy_after, done_after, valid_any, busy_c1;

    always #5 clk = ~clk;

    shape_rasterizer #(.SCREEN_W(4), .SCREEN_H(4)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .shape_type(shape_type),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_enable(fill_enable),
        .color(color), .bg_color(bg_color), .pix_valid(pv_s), .pix_ready(rdy_s),
        .pix_x(px_s), .pix_y(py_s), .pix_color(pc_s), .busy(busy_s),
        .done(done_s), .cmd_err(err_s)
    );

    shape_rasterizer #(.SCREEN_W(128), .SCREEN_H(128)) u_big (
        .clk(clk), .rst(rst), .start(start_b), .shape_type(shape_type),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_enable(fill_enable),
        .color(color), .bg_color(bg_color), .pix_valid(pv_b), .pix_ready(rdy_b),
        .pix_x(px_b), .pix_y(py_b), .pix_color(pc_b), .busy(busy_b),
        .done(done_b), .cmd_err(err_b)
    );

    // Issue one command and record every handshake until done or timeout.
    // rmode 0: always ready, 1: pseudo-random ready. inj_cyc: cycle to pulse
    // a stray start (0 = never). inj_done: pulse start in the done cycle.
    task automatic run_cmd(input bit sm, input logic [3:0] st,
                           input logic [7:0] ax0, input logic [7:0] ay0,
                           input logic [7:0] ax1, input logic [7:0] ay1,
                           input bit fill, input int rmode, input int inj_cyc,
                           input bit inj_done, input logic [23:0] exp_col);
        int c;
        bit r, prev_stall;
        logic ov, obusy, odone, oerr;
        logic [7:0] ox, oy, sx, sy;
        logic [23:0] oc, scol;
        got.delete();
        first_vld = -1; done_cyc = -1; last_hs = -1; stall_bad = 0; color_bad = 0;
        got_done = 0; err_at_done = 0; busy_at_done = 0; valid_any = 0;
        prev_stall = 0; sx = '0; sy = '0; scol = '0;
        @(negedge clk);
        shape_type = st; x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; fill_enable = fill;
        if (sm) start_s = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_s = 1'b0; start_b = 1'b0;
        c = 1;
        while (c <= 2000) begin
            ov    = sm ? pv_s : pv_b;
            ox    = sm ? px_s : px_b;
            oy    = sm ? py_s : py_b;
            oc    = sm ? pc_s : pc_b;
            obusy = sm ? busy_s : busy_b;
            odone = sm ? done_s : done_b;
            oerr  = sm ? err_s : err_b;
            if (c == 1) busy_c1 = obusy;
            if (prev_stall && !(ov === 1'b1 && ox === sx && oy === sy && oc === scol))
                stall_bad++;
            if (odone === 1'b1) begin
                got_done = 1; done_cyc = c; err_at_done = oerr; busy_at_done = obusy;
                if (inj_done) begin
                    if (sm) start_s = 1'b1; else start_b = 1'b1;
                end
                break;
            end
            if (ov === 1'b1) begin
                valid_any = 1;
                if (first_vld < 0) first_vld = c;
            end
            r = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (sm) rdy_s = r; else rdy_b = r;
            if (inj_cyc == c) begin
                shape_type = 4'd0;
                if (sm) start_s = 1'b1; else start_b = 1'b1;
            end else begin
                start_s = 1'b0; start_b = 1'b0;
            end
            if (ov === 1'b1 && r) begin
                got.push_back({ox, oy});
                if (oc !== exp_col) color_bad++;
                last_hs = c;
            end
            prev_stall = (ov === 1'b1) && !r;
            sx = ox; sy = oy; scol = oc;
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        start_s = 1'b0; start_b = 1'b0;
        rdy_s = 1'b1; rdy_b = 1'b1;
        busy_after = sm ? busy_s : busy_b;
        done_after = sm ? done_s : done_b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if ({pv_s, busy_s, done_s, err_s, px_s, py_s, pc_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_small: got %h required 0", {pv_s, busy_s, done_s, err_s, px_s, py_s, pc_s});
        end
        n_assert++;
        if ({pv_b, busy_b, done_b, err_b, px_b, py_b, pc_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_big: got %h required 0", {pv_b, busy_b, done_b, err_b, px_b, py_b, pc_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (busy_b !== 1'b0 || pv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy_b, pv_b);
        end
    endtask

    task automatic test_clear;
        logic [15:0] exp[$];
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                exp.push_back({8'(x), 8'(y)});
        run_cmd(1'b1, 4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0, 1'b0, BG);
        n_assert++;
        if (got.size() !== exp.size()) begin
            n_fail++; $display("FAIL clear_count: got %0d required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_assert++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL clear_pix[%0d]: got %h required %h", i, got[i], exp[i]);
            end
        end
        n_assert++;
        if (color_bad !== 0) begin
            n_fail++; $display("FAIL clear_color: %0d pixels not %h", color_bad, BG);
        end
        n_assert++;
        if (busy_c1 !== 1'b1) begin
            n_fail++; $display("FAIL clear_busy_setup: got %b required 1", busy_c1);
        end
        n_assert++;
        if (first_vld !== 2) begin
            n_fail++; $display("FAIL clear_first_valid: got cycle %0d required 2", first_vld);
        end
        n_assert++;
        if (!got_done || done_cyc !== last_hs + 1) begin
            n_fail++; $display("FAIL clear_done_timing: got cycle %0d required %0d", done_cyc, last_hs + 1);
        end
        n_assert++;
        if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || done_after !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done_pulse: busy@done=%b busy/done after=%b%b required 1 00",
                     busy_at_done, busy_after, done_after);
        end
    endtask

    task automatic test_line;
        logic [15:0] fwd[$];
        logic [15:0] rev[$];
        fwd = '{16'h0000, 16'h0100, 16'h0201, 16'h0301};
        rev = '{16'h0301, 16'h0201, 16'h0100, 16'h0000};
        run_cmd(1'b0, 4'd1, 8'd0, 8'd0, 8'd3, 8'd1, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== fwd.size() || !got_done) begin
            n_fail++; $display("FAIL line_fwd_count: got %0d done=%b required 4 done=1", got.size(), got_done);
        end
        for (int i = 0; i < fwd.size() && i < got.size(); i++) begin
            n_assert++;
            if (got[i] !== fwd[i]) begin
                n_fail++; $display("FAIL line_fwd_pix[%0d]: got %h required %h", i, got[i], fwd[i]);
            end
        end
        n_assert++;
        if (color_bad !== 0 || first_vld !== 2) begin
            n_fail++; $display("FAIL line_fwd_color_latency: bad=%0d first=%0d required 0 2", color_bad, first_vld);
        end
        run_cmd(1'b0, 4'd1, 8'd3, 8'd1, 8'd0, 8'd0, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== rev.size() || !got_done) begin
            n_fail++; $display("FAIL line_rev_count: got %0d done=%b required 4 done=1", got.size(), got_done);
        end
        for (int i = 0; i < rev.size() && i < got.size(); i++) begin
            n_assert++;
            if (got[i] !== rev[i]) begin
                n_fail++; $display("FAIL line_rev_pix[%0d]: got %h required %h", i, got[i], rev[i]);
            end
        end
        run_cmd(1'b0, 4'd1, 8'd9, 8'd7, 8'd9, 8'd7, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== 1 || (got.size() == 1 && got[0] !== 16'h0907)) begin
            n_fail++; $display("FAIL line_point: got %0d pixels required 1 at 0907", got.size());
        end
    endtask

    task automatic test_rect;
        logic [15:0] outl[$];
        logic [15:0] fill[$];
        outl = '{16'h0202, 16'h0302, 16'h0402, 16'h0203, 16'h0403, 16'h0204, 16'h0304, 16'h0404};
        fill = '{16'h0202, 16'h0302, 16'h0402, 16'h0203, 16'h0303, 16'h0403, 16'h0204, 16'h0304, 16'h0404};
        run_cmd(1'b0, 4'd2, 8'd4, 8'd4, 8'd2, 8'd2, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== outl.size() || !got_done) begin
            n_fail++; $display("FAIL rect_outline_count: got %0d done=%b required 8 done=1", got.size(), got_done);
        end
        for (int i = 0; i < outl.size() && i < got.size(); i++) begin
            n_assert++;
            if (got[i] !== outl[i]) begin
                n_fail++; $display("FAIL rect_outline_pix[%0d]: got %h required %h", i, got[i], outl[i]);
            end
        end
        n_assert++;
        if (done_cyc !== last_hs + 1) begin
            n_fail++; $display("FAIL rect_outline_no_gaps: done %0d required %0d", done_cyc, last_hs + 1);
        end
        run_cmd(1'b0, 4'd2, 8'd4, 8'd4, 8'd2, 8'd2, 1'b1, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== fill.size() || !got_done) begin
            n_fail++; $display("FAIL rect_fill_count: got %0d done=%b required 9 done=1", got.size(), got_done);
        end
        for (int i = 0; i < fill.size() && i < got.size(); i++) begin
            n_assert++;
            if (got[i] !== fill[i]) begin
                n_fail++; $display("FAIL rect_fill_pix[%0d]: got %h required %h", i, got[i], fill[i]);
            end
        end
        run_cmd(1'b0, 4'd2, 8'd5, 8'd1, 8'd5, 8'd3, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== 3 || (got.size() == 3 && (got[0] !== 16'h0501 || got[2] !== 16'h0503))) begin
            n_fail++; $display("FAIL rect_one_column: got %0d pixels required 3 (0501..0503)", got.size());
        end
    endtask

    task automatic test_clip;
        run_cmd(1'b0, 4'd1, 8'd126, 8'd0, 8'd129, 8'd0, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== 2 || (got.size() == 2 && (got[0] !== 16'h7E00 || got[1] !== 16'h7F00))) begin
            n_fail++; $display("FAIL clip_pixels: got %0d pixels required 2 (7E00,7F00)", got.size());
        end
        n_assert++;
        if (!got_done || done_cyc !== 6) begin
            n_fail++; $display("FAIL clip_done: got done=%b cycle %0d required 1 cycle 6", got_done, done_cyc);
        end
        run_cmd(1'b0, 4'd1, 8'd126, 8'd0, 8'd129, 8'd0, 1'b0, 1, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== 2 || (got.size() == 2 && (got[0] !== 16'h7E00 || got[1] !== 16'h7F00)) || !got_done) begin
            n_fail++; $display("FAIL clip_stall_pixels: got %0d pixels done=%b required 2 done=1", got.size(), got_done);
        end
        run_cmd(1'b0, 4'd2, 8'd10, 8'd20, 8'd14, 8'd23, 1'b1, 1, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== 20 || stall_bad !== 0 || color_bad !== 0) begin
            n_fail++;
            $display("FAIL stall_rect: got %0d pixels, %0d unstable, %0d bad colour, required 20 0 0",
                     got.size(), stall_bad, color_bad);
        end
    endtask

    task automatic test_unsupported;
        run_cmd(1'b0, 4'd5, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (!got_done || done_cyc !== 2 || err_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL unsupported_done: done=%b cycle %0d err=%b required 1 2 1", got_done, done_cyc, err_at_done);
        end
        n_assert++;
        if (valid_any !== 1'b0 || got.size() !== 0) begin
            n_fail++; $display("FAIL unsupported_no_pixels: valid seen=%b pixels=%0d required 0 0", valid_any, got.size());
        end
    endtask

    task automatic test_busy_start;
        run_cmd(1'b0, 4'd2, 8'd2, 8'd2, 8'd4, 8'd4, 1'b1, 0, 4, 1'b1, FG);
        n_assert++;
        if (got.size() !== 9 || !got_done || (got.size() == 9 && got[4] !== 16'h0303)) begin
            n_fail++; $display("FAIL busy_start_pixels: got %0d done=%b required 9 done=1", got.size(), got_done);
        end
        n_assert++;
        if (busy_after !== 1'b0) begin
            n_fail++; $display("FAIL start_in_done_ignored: busy after=%b required 0", busy_after);
        end
    endtask

    task automatic test_reset_mid_line;
        int seen;
        logic [15:0] fwd[$];
        fwd = '{16'h0000, 16'h0100, 16'h0201, 16'h0301};
        @(negedge clk);
        shape_type = 4'd1; x0 = 8'd0; y0 = 8'd0; x1 = 8'd100; y1 = 8'd50;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (4) @(negedge clk);
        n_assert++;
        if (pv_b !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL midline_active: valid=%b busy=%b required 1 1", pv_b, busy_b);
        end
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({pv_b, busy_b, done_b, err_b, px_b, py_b, pc_b} !== '0) begin
            n_fail++; $display("FAIL midline_reset_outputs: got %h required 0", {pv_b, busy_b, done_b, err_b, px_b, py_b, pc_b});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_b !== 1'b0 || busy_b !== 1'b0 || pv_b !== 1'b0) seen++;
        end
        n_assert++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midline_quiet_after_reset: %0d active cycles required 0", seen);
        end
        run_cmd(1'b0, 4'd1, 8'd0, 8'd0, 8'd3, 8'd1, 1'b0, 0, 0, 1'b0, FG);
        n_assert++;
        if (got.size() !== 4 || !got_done) begin
            n_fail++; $display("FAIL after_reset_count: got %0d done=%b required 4 done=1", got.size(), got_done);
        end
        for (int i = 0; i < fwd.size() && i < got.size(); i++) begin
            n_assert++;
            if (got[i] !== fwd[i]) begin
                n_fail++; $display("FAIL after_reset_pix[%0d]: got %h required %h", i, got[i], fwd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_line();
        test_rect();
        test_clip();
        test_unsupported();
        test_busy_start();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
